// File: rtl/maj_seq_pkg.sv
// maj_seq_pkg: shared types and constants for the sequential majority-graph
// evaluator (maj_seq_eval) and its MAJ3 datapath unit.
//
// Contents:
//   NUM_IN / NUM_NODES     primary input count and node-table depth
//   SEL_W / NODE_W         operand select width and packed node-entry width
//   opnd_t                 {inv, sel} operand descriptor
//   node_t                 {c, b, a} node entry, operand A in the LSBs
//   state_t                evaluator FSM state
//   SEL_ZERO/SEL_X_BASE/SEL_W_BASE  operand select code map
package maj_seq_pkg;

  localparam int NUM_IN     = 7;
  localparam int NUM_NODES  = 8;
  localparam int SEL_W      = $clog2(1 + NUM_IN + NUM_NODES);
  localparam int NODE_W     = 3 * (SEL_W + 1);
  localparam int IDX_W      = $clog2(NUM_NODES);
  localparam int LEN_W      = IDX_W + 1;

  // Select codes: 0 = constant 0, then x0.., then w0..
  localparam int SEL_ZERO   = 0;
  localparam int SEL_X_BASE = 1;
  localparam int SEL_W_BASE = NUM_IN + 1;

  typedef struct packed {
    logic             inv;
    logic [SEL_W-1:0] sel;
  } opnd_t;

  typedef struct packed {
    opnd_t c;
    opnd_t b;
    opnd_t a;
  } node_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/maj_seq_eval_maj3.sv
// maj3_unit: the single shared combinational 3-input majority.
//
// Configuration macro: MAJ_INV_EN
//   defined   - inv[i] complements operand i before the majority
//   undefined - inv bits are ignored (plain MAJ3)
//
// Ports:
//   a, b, c  in  operand values
//   inv      in  per-operand complement flags {c, b, a}
//   y        out MAJ(a', b', c')
module maj3_unit (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [2:0] inv,
  output logic       y
);

  logic ea, eb, ec;

`ifdef MAJ_INV_EN
  assign ea = a ^ inv[0];
  assign eb = b ^ inv[1];
  assign ec = c ^ inv[2];
`else
  logic unused_inv;
  assign unused_inv = ^inv;
  assign ea = a;
  assign eb = b;
  assign ec = c;
`endif

  assign y = (ea & eb) | (ea & ec) | (eb & ec);

endmodule

// File: rtl/maj_seq_eval.sv
// maj_seq_eval: sequential majority-graph evaluator. A programmable table of
// up to NUM_NODES MAJ3 nodes is evaluated one node per cycle on a single
// shared maj3_unit; the last evaluated node is the function value.
//
// Configuration macro: MAJ_INV_EN (operand complement, see maj3_unit).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_we/addr/wdata    node-table write port (honoured only in IDLE)
//   in_valid/in_ready    input vector handshake
//   in_x, in_len         input vector and number of nodes to evaluate
//   out_valid/out_ready  result handshake
//   out_bit              function value, stable while out_valid
//   busy                 high while evaluating or holding a result
module maj_seq_eval
  import maj_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [NODE_W-1:0] cfg_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] in_x,
  input  logic [LEN_W-1:0]  in_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              busy
);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [LEN_W-1:0]      len;
  logic [NUM_IN-1:0]     xr;
  logic [NUM_NODES-1:0]  w;
  logic                  obit;
  logic [NODE_W-1:0]     tbl [NUM_NODES];

  node_t                 nd;
  logic                  va, vb, vc, maj;
  logic                  last;
  logic                  len_bad;

  // Operand fetch: constant 0, a latched input, or a node result. Codes
  // that map to nothing read 0. Nodes not yet evaluated still hold the 0
  // cleared at acceptance, which gives forward references their value.
  function automatic logic opnd_val(input logic [SEL_W-1:0]     sel,
                                    input logic [NUM_IN-1:0]    x,
                                    input logic [NUM_NODES-1:0] wv);
    logic v;
    v = 1'b0;
    for (int i = 0; i < NUM_IN; i++)
      if (sel == SEL_W'(SEL_X_BASE + i)) v = x[i];
    for (int k = 0; k < NUM_NODES; k++)
      if (sel == SEL_W'(SEL_W_BASE + k)) v = wv[k];
    return v;
  endfunction

  assign nd = node_t'(tbl[idx]);
  assign va = opnd_val(nd.a.sel, xr, w);
  assign vb = opnd_val(nd.b.sel, xr, w);
  assign vc = opnd_val(nd.c.sel, xr, w);

  maj3_unit u_maj3 (
    .a   (va),
    .b   (vb),
    .c   (vc),
    .inv ({nd.c.inv, nd.b.inv, nd.a.inv}),
    .y   (maj)
  );

  assign last    = (LEN_W'(idx) + LEN_W'(1)) == len;
  assign len_bad = (in_len == '0) || (in_len > LEN_W'(NUM_NODES));

  // Handshake and status come straight from the state register.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_bit   = obit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      len   <= '0;
      xr    <= '0;
      w     <= '0;
      obit  <= 1'b0;
      for (int k = 0; k < NUM_NODES; k++) tbl[k] <= '0;
    end else begin
      case (state)
        // IDLE: table writes allowed; a write landing on the acceptance
        // edge is already in the table when EVAL reads it next cycle.
        ST_IDLE: begin
          if (cfg_we) tbl[cfg_addr] <= cfg_wdata;
          if (in_valid) begin
            xr   <= in_x;
            len  <= in_len;
            w    <= '0;
            idx  <= '0;
            obit <= 1'b0;
            state <= len_bad ? ST_DONE : ST_EVAL;
          end
        end
        // EVAL: one node per cycle; the final node also becomes the result.
        ST_EVAL: begin
          w[idx] <= maj;
          idx    <= idx + IDX_W'(1);
          if (last) begin
            obit  <= maj;
            state <= ST_DONE;
          end
        end
        // DONE: hold the result until the consumer takes it.
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
